nor_gate_3in: RTL and testbench

- Bitwise 3-input NOR primitive for the logic-gate library: F = ~(a | b | c), per bit, over a WIDTH-bit vector.
- Provides a combinational output plus a registered copy with a valid flag, so it can be dropped into clocked datapaths.
- A leaf cell with no downstream handshake back-pressure.

---
 rtl/nor_gate_pkg.sv | 13 +
 rtl/nor_gate_3in_if.sv | 24 ++
 rtl/nor3_cov_tracker.sv | 31 +++
 rtl/nor_gate_3in.sv | 43 ++++
 tb/tb_nor_gate_3in.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nor_gate_pkg.sv
// nor_gate_pkg: shared constants and the bitwise 3-input NOR helper for nor_gate_3in.
package nor_gate_pkg;
    localparam int NOR3_COMBOS    = 8;
    localparam int NOR3_WIDTH_MAX = 64;

    function automatic logic [NOR3_WIDTH_MAX-1:0] nor3(
        input logic [NOR3_WIDTH_MAX-1:0] a,
        input logic [NOR3_WIDTH_MAX-1:0] b,
        input logic [NOR3_WIDTH_MAX-1:0] c
    );
        return ~(a | b | c);
    endfunction
endpackage

// File: rtl/nor_gate_3in_if.sv
// nor_gate_3in_if: operand/result bundle for nor_gate_3in; NOR3_COVERAGE_EN adds cov_mask/cov_done.
interface nor_gate_3in_if
    import nor_gate_pkg::*;
#(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             in_valid;
    logic [WIDTH-1:0] F;
    logic [WIDTH-1:0] F_q;
    logic             out_valid;
`ifdef NOR3_COVERAGE_EN
    logic [NOR3_COMBOS-1:0] cov_mask;
    logic                   cov_done;

    modport master (output a, b, c, in_valid, input F, F_q, out_valid, cov_mask, cov_done);
    modport slave  (input a, b, c, in_valid, output F, F_q, out_valid, cov_mask, cov_done);
`else
    modport master (output a, b, c, in_valid, input F, F_q, out_valid);
    modport slave  (input a, b, c, in_valid, output F, F_q, out_valid);
`endif
endinterface

// File: rtl/nor3_cov_tracker.sv
// nor3_cov_tracker: sticky record of captured {a[0],b[0],c[0]} combinations (NOR3_COVERAGE_EN only).
module nor3_cov_tracker
    import nor_gate_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    input  logic [2:0]             i_abc,
    output logic [NOR3_COMBOS-1:0] o_cov_mask,
    output logic                   o_cov_done
);
    logic [NOR3_COMBOS-1:0] r_mask;
    logic                   r_done;
    logic [NOR3_COMBOS-1:0] w_mask_nxt;

    // done tracks the next mask so both flags move on the same capture edge
    assign w_mask_nxt = i_valid ? (r_mask | (NOR3_COMBOS'(1) << i_abc)) : r_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask <= '0;
            r_done <= 1'b0;
        end else begin
            r_mask <= w_mask_nxt;
            r_done <= &w_mask_nxt;
        end
    end

    assign o_cov_mask = r_mask;
    assign o_cov_done = r_done;
endmodule

// File: rtl/nor_gate_3in.sv
// nor_gate_3in: bitwise 3-input NOR with combinational and registered outputs.
// Optional macro NOR3_COVERAGE_EN adds input-combination coverage outputs.
module nor_gate_3in
    import nor_gate_pkg::*;
#(
    parameter int WIDTH = 1
)(
    input logic           clk,
    input logic           rst_n,
    nor_gate_3in_if.slave bus
);
    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] r_f_q;
    logic             r_out_valid;

    assign w_f = WIDTH'(nor3(NOR3_WIDTH_MAX'(bus.a), NOR3_WIDTH_MAX'(bus.b), NOR3_WIDTH_MAX'(bus.c)));

    // F_q holds across invalid cycles; only out_valid drops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_f_q       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) r_f_q <= w_f;
        end
    end

    assign bus.F         = w_f;
    assign bus.F_q       = r_f_q;
    assign bus.out_valid = r_out_valid;

`ifdef NOR3_COVERAGE_EN
    nor3_cov_tracker u_cov (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (bus.in_valid),
        .i_abc      ({bus.a[0], bus.b[0], bus.c[0]}),
        .o_cov_mask (bus.cov_mask),
        .o_cov_done (bus.cov_done)
    );
`endif
endmodule

// File: tb/tb_nor_gate_3in.sv
// tb_nor_gate_3in: directed and randomized checks of nor_gate_3in at WIDTH=1 and WIDTH=8.
// Coverage outputs are checked when NOR3_COVERAGE_EN is defined.
module tb_nor_gate_3in;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nor_gate_3in_if #(.WIDTH(1)) if1 ();
    nor_gate_3in_if #(.WIDTH(8)) if8 ();

    nor_gate_3in #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    nor_gate_3in #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    // reference: an output bit is 1 exactly when none of its three inputs is 1
    function automatic logic ref1(input logic a, input logic b, input logic c);
        return (int'(a) + int'(b) + int'(c)) == 0;
    endfunction

    function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = ref1(a[i], b[i], c[i]);
        return r;
    endfunction

    logic       m1_fq = 1'b0;
    logic       m1_ov = 1'b0;
    logic [7:0] m8_fq = 8'h00;
    logic       m8_ov = 1'b0;
    logic [7:0] m_cov = 8'h00;
    logic       m_done = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m1_fq  <= 1'b0;
            m1_ov  <= 1'b0;
            m8_fq  <= 8'h00;
            m8_ov  <= 1'b0;
            m_cov  <= 8'h00;
            m_done <= 1'b0;
        end else begin
            m1_ov <= if1.in_valid;
            m8_ov <= if8.in_valid;
            if (if1.in_valid) m1_fq <= ref1(if1.a, if1.b, if1.c);
            if (if8.in_valid) m8_fq <= ref8(if8.a, if8.b, if8.c);
            if (if1.in_valid) begin
                m_cov  <= m_cov | (8'd1 << (int'(if1.a) * 4 + int'(if1.b) * 2 + int'(if1.c)));
                m_done <= (m_cov | (8'd1 << (int'(if1.a) * 4 + int'(if1.b) * 2 + int'(if1.c)))) == 8'hFF;
            end
        end
    end

    task automatic drive(input logic [2:0] abc, input logic v);
        if1.a = abc[2];
        if1.b = abc[1];
        if1.c = abc[0];
        if1.in_valid = v;
        if8.a = {8{abc[2]}};
        if8.b = {8{abc[1]}};
        if8.c = {8{abc[0]}};
        if8.in_valid = v;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(3'b000, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if ({if1.F_q, if1.out_valid, if1.F} !== 3'b001) begin
                errors++;
                $display("FAIL reset_hold: {F_q,out_valid,F}=%b required 001", {if1.F_q, if1.out_valid, if1.F});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({if1.F_q, if1.out_valid} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release: {F_q,out_valid}=%b required 11", {if1.F_q, if1.out_valid});
        end
    endtask

    task automatic test_truth_table();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(i[2:0], 1'b0);
            #2;
            checks++;
            if (if1.F !== (i == 0) || if8.F !== ((i == 0) ? 8'hFF : 8'h00)) begin
                errors++;
                $display("FAIL truth_table abc=%03b: F1=%b F8=%h required %b", i[2:0], if1.F, if8.F, i == 0);
            end
            #2;
        end
    endtask

    task automatic test_registered_path();
        @(negedge clk);
        rst_n = 1'b0;
        drive(3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(i[2:0], 1'b1);
            @(posedge clk);
            #1;
            checks++;
            if (if1.F_q !== (i == 0) || if1.out_valid !== 1'b1 || if1.F_q !== m1_fq || if8.F_q !== m8_fq) begin
                errors++;
                $display("FAIL registered_path abc=%03b: F_q=%b out_valid=%b F8_q=%h required %b 1 %h",
                         i[2:0], if1.F_q, if1.out_valid, if8.F_q, i == 0, m8_fq);
            end
            @(negedge clk);
        end
        drive(3'b000, 1'b0);
`ifdef NOR3_COVERAGE_EN
        checks++;
        if (if1.cov_mask !== 8'hFF || if1.cov_done !== 1'b1) begin
            errors++;
            $display("FAIL cov_full: mask=%h done=%b required FF 1", if1.cov_mask, if1.cov_done);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (if1.cov_mask !== 8'h00 || if1.cov_done !== 1'b0) begin
            errors++;
            $display("FAIL cov_reset: mask=%h done=%b required 00 0", if1.cov_mask, if1.cov_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b000, 1'b1);
        @(negedge clk);
        drive(3'b111, 1'b1);
        @(negedge clk);
        drive(3'b000, 1'b0);
        checks++;
        if (if1.cov_mask !== 8'h81 || if1.cov_done !== 1'b0) begin
            errors++;
            $display("FAIL cov_partial: mask=%h done=%b required 81 0", if1.cov_mask, if1.cov_done);
        end
`endif
    endtask

    task automatic test_valid_gating();
        @(negedge clk);
        drive(3'b000, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (if1.F_q !== 1'b1 || if8.F_q !== 8'hFF) begin
            errors++;
            $display("FAIL gating_capture: F_q=%b F8_q=%h required 1 FF", if1.F_q, if8.F_q);
        end
        @(negedge clk);
        drive(3'b111, 1'b0);
        #1;
        checks++;
        if (if1.F !== 1'b0 || if8.F !== 8'h00) begin
            errors++;
            $display("FAIL gating_comb: F=%b F8=%h required 0 00", if1.F, if8.F);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (if1.F_q !== 1'b1 || if1.out_valid !== 1'b0 || if8.F_q !== 8'hFF || if8.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL gating_hold: F_q=%b out_valid=%b F8_q=%h required 1 0 FF", if1.F_q, if1.out_valid, if8.F_q);
            end
        end
    endtask

    task automatic test_width8();
        @(negedge clk);
        drive(3'b000, 1'b0);
        if8.a = 8'hF0;
        if8.b = 8'h0C;
        if8.c = 8'h01;
        if8.in_valid = 1'b1;
        #1;
        checks++;
        if (if8.F !== 8'h02) begin
            errors++;
            $display("FAIL width8_comb: F=%h required 02", if8.F);
        end
        @(posedge clk);
        #1;
        checks++;
        if (if8.F_q !== 8'h02 || if8.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL width8_reg: F_q=%h out_valid=%b required 02 1", if8.F_q, if8.out_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            checks++;
            if (if1.F !== ref1(if1.a, if1.b, if1.c) || if8.F !== ref8(if8.a, if8.b, if8.c) ||
                if1.F_q !== m1_fq || if1.out_valid !== m1_ov || if8.F_q !== m8_fq || if8.out_valid !== m8_ov) begin
                errors++;
                $display("FAIL random n=%0d: F=%b F8=%h F_q=%b ov=%b F8_q=%h ov8=%b required F_q=%b ov=%b F8_q=%h ov8=%b",
                         n, if1.F, if8.F, if1.F_q, if1.out_valid, if8.F_q, if8.out_valid, m1_fq, m1_ov, m8_fq, m8_ov);
            end
`ifdef NOR3_COVERAGE_EN
            checks++;
            if (if1.cov_mask !== m_cov || if1.cov_done !== m_done) begin
                errors++;
                $display("FAIL random_cov n=%0d: mask=%h done=%b required %h %b", n, if1.cov_mask, if1.cov_done, m_cov, m_done);
            end
`endif
            rst_n = ($urandom_range(0, 15) != 0);
            if1.a = 1'($urandom);
            if1.b = 1'($urandom);
            if1.c = 1'($urandom);
            if1.in_valid = 1'($urandom);
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            if8.c = 8'($urandom);
            if8.in_valid = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(3'b000, 1'b0);
        test_reset();
        test_truth_table();
        test_registered_path();
        test_valid_gating();
        test_width8();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
